// File: rtl/pd_pkg.sv
// Shared constants and state encoding for the block-header packer.
package pd_pkg;

  localparam int PD_HDR_WORDS    = 20;
  localparam int PD_WORD_W       = 32;
  localparam int PD_CHUNK1_W     = 512;
  localparam int PD_CHUNK2_W     = 128;
  localparam int PD_CHUNK1_WORDS = PD_CHUNK1_W / PD_WORD_W;
  localparam int PD_CHUNK2_WORDS = PD_CHUNK2_W / PD_WORD_W;

  typedef enum logic [1:0] {PD_IDLE, PD_FILL, PD_FULL} pd_pack_state_t;

endpackage

// File: rtl/pd_word_counter.sv
// Counts header words accepted so far; saturates at HDR_WORDS and flags the
// last word slot so the packer knows which transfer completes the header.
module pd_word_counter
  import pd_pkg::*;
#(
  parameter int HDR_WORDS = PD_HDR_WORDS
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       en,
  input  logic       clr,
  output logic [4:0] count,
  output logic       terminal
);

  // Clear has priority so an abort or ack always lands on zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != 5'(HDR_WORDS))) begin
      count <= count + 5'd1;
    end
  end

  assign terminal = (count == 5'(HDR_WORDS - 1));

endmodule

// File: rtl/pd_header_packer.sv
// Packs 20 streamed 32-bit words into chunk_1/chunk_2 and holds them behind a
// valid/ack handshake. Define PD_NONCE_OVERRIDE_EN to allow nonce rewrites in FULL.
module pd_header_packer
  import pd_pkg::*;
#(
  parameter int HDR_WORDS = PD_HDR_WORDS,
  parameter int WORD_W    = PD_WORD_W
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [WORD_W-1:0]      word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
  input  logic                   abort,
  output logic [PD_CHUNK1_W-1:0] chunk_1,
  output logic [PD_CHUNK2_W-1:0] chunk_2,
  output logic                   block_valid,
  input  logic                   block_ack,
  output logic [4:0]             word_count
`ifdef PD_NONCE_OVERRIDE_EN
  ,
  input  logic [WORD_W-1:0]      nonce_in,
  input  logic                   nonce_load
`endif
);

  pd_pack_state_t state;
  logic [4:0]     count;
  logic           terminal;
  logic           take;
  logic           release_hdr;

  assign word_ready  = (state != PD_FULL);
  assign take        = word_valid && word_ready && !abort;
  assign release_hdr = (state == PD_FULL) && block_ack;
  assign word_count  = count;

  pd_word_counter #(
    .HDR_WORDS(HDR_WORDS)
  ) u_word_counter (
    .clk     (clk),
    .n_rst   (n_rst),
    .en      (take),
    .clr     (abort || release_hdr),
    .count   (count),
    .terminal(terminal)
  );

  // Chunk data is never cleared on ack/abort; only reset or a new word overwrites it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= PD_IDLE;
      block_valid <= 1'b0;
      chunk_1     <= '0;
      chunk_2     <= '0;
    end else begin
      if (take) begin
        for (int k = 0; k < PD_CHUNK1_WORDS; k++) begin
          if (count == 5'(k)) chunk_1[PD_CHUNK1_W-1-WORD_W*k -: WORD_W] <= word_in;
        end
        for (int k = 0; k < PD_CHUNK2_WORDS; k++) begin
          if (count == 5'(PD_CHUNK1_WORDS + k)) chunk_2[PD_CHUNK2_W-1-WORD_W*k -: WORD_W] <= word_in;
        end
      end
`ifdef PD_NONCE_OVERRIDE_EN
      if ((state == PD_FULL) && nonce_load && !abort) chunk_2[WORD_W-1:0] <= nonce_in;
`endif
      if (abort) begin
        state       <= PD_IDLE;
        block_valid <= 1'b0;
      end else begin
        case (state)
          PD_IDLE: if (take) state <= PD_FILL;
          PD_FILL: begin
            if (take && terminal) begin
              state       <= PD_FULL;
              block_valid <= 1'b1;
            end
          end
          PD_FULL: begin
            if (block_ack) begin
              state       <= PD_IDLE;
              block_valid <= 1'b0;
            end
          end
          default: begin
            state       <= PD_IDLE;
            block_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
